// File: rtl/fifo_chunk_submit_pkg.sv
// Shared types and helpers for the chunk-submit FIFO.
package fifo_chunk_submit_pkg;

  // One bit per submit cause, so the reason for a submit is visible in a waveform.
  typedef struct packed {
    logic chunk;
    logic idle;
    logic flush;
  } trig_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_chunk_submit_if.sv
// Write/read handshake bundle for fifo_chunk_submit.
// i_flush exists only when FIFO_CHUNK_SUBMIT_FLUSH_EN is defined.
interface fifo_chunk_submit_if #(
  parameter int DW = 8,
  parameter int AW = 10
) ();

  logic          i_rdy;
  logic          i_en;
  logic [DW-1:0] i_data;
`ifdef FIFO_CHUNK_SUBMIT_FLUSH_EN
  logic          i_flush;
`endif
  logic          o_rdy;
  logic          o_en;
  logic [DW-1:0] o_data;
  logic [AW:0]   o_pending;
  logic [AW:0]   o_avail;

`ifdef FIFO_CHUNK_SUBMIT_FLUSH_EN
  modport master (
    input  i_rdy, o_en, o_data, o_pending, o_avail,
    output i_en, i_data, i_flush, o_rdy
  );
  modport slave (
    output i_rdy, o_en, o_data, o_pending, o_avail,
    input  i_en, i_data, i_flush, o_rdy
  );
`else
  modport master (
    input  i_rdy, o_en, o_data, o_pending, o_avail,
    output i_en, i_data, o_rdy
  );
  modport slave (
    output i_rdy, o_en, o_data, o_pending, o_avail,
    input  i_en, i_data, o_rdy
  );
`endif

endinterface

// File: rtl/fifo_chunk_submit_ram.sv
// Simple dual-port RAM for fifo_chunk_submit: synchronous write, registered read.
module fifo_chunk_ram #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_chunk_submit.sv
// Delay-submit FIFO: words become readable on a CHUNK fill, an idle TIMEOUT,
// or (with FIFO_CHUNK_SUBMIT_FLUSH_EN defined) an external i_flush pulse.
module fifo_chunk_submit
  import fifo_chunk_submit_pkg::*;
#(
  parameter int DW      = 8,
  parameter int AW      = 10,
  parameter int CHUNK   = 128,
  parameter int TIMEOUT = 2048
) (
  input  logic               clk,
  input  logic               rstn,
  fifo_chunk_submit_if.slave bus
);

  localparam int            CW        = clog2(TIMEOUT);
  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   CHUNK_LVL = (AW+1)'(CHUNK);

  logic [AW:0]   wptr_q, wptr_d;
  logic [AW:0]   sptr_q, sptr_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [CW-1:0] idle_q, idle_d;
  logic          o_en_q, o_en_d;
  logic [AW:0]   pending, avail;
  logic          full, wr_acc, rd_acc, submit, flush_req;
  logic [DW-1:0] rd_data;
  trig_t         trig;

`ifdef FIFO_CHUNK_SUBMIT_FLUSH_EN
  assign flush_req = bus.i_flush;
`else
  assign flush_req = 1'b0;
`endif

  always_comb begin
    pending = wptr_q - sptr_q;
    avail   = sptr_q - rptr_q;
    full    = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
    wr_acc  = bus.i_en & ~full;
    rd_acc  = o_en_q & bus.o_rdy;
    wptr_d  = wptr_q + (AW+1)'(wr_acc);
    rptr_d  = rptr_q + (AW+1)'(rd_acc);

    trig       = '0;
    trig.chunk = (pending >= CHUNK_LVL);
    trig.idle  = (idle_q == IDLE_LAST);
    trig.flush = flush_req;
    submit     = |trig;

    // Submitting wptr_d rather than wptr_q folds a same-cycle write into the chunk.
    sptr_d = submit ? wptr_d : sptr_q;
    idle_d = (wr_acc | submit) ? '0 : idle_q + CW'(1);
    o_en_d = (rptr_d != sptr_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      sptr_q <= '0;
      rptr_q <= '0;
      idle_q <= '0;
      o_en_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      sptr_q <= sptr_d;
      rptr_q <= rptr_d;
      idle_q <= idle_d;
      o_en_q <= o_en_d;
    end
  end

  // The RAM read register is the output data register; reading at rptr_d
  // gives first-word-fall-through and holds o_data while o_rdy is low.
  fifo_chunk_ram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q[AW-1:0]),
    .wdata (bus.i_data),
    .raddr (rptr_d[AW-1:0]),
    .rdata (rd_data)
  );

  assign bus.i_rdy     = ~full;
  assign bus.o_en      = o_en_q;
  assign bus.o_data    = rd_data;
  assign bus.o_pending = pending;
  assign bus.o_avail   = avail;

endmodule

// File: tb/tb_fifo_chunk_submit.sv
// Directed bench for fifo_chunk_submit (AW=3, CHUNK=4, TIMEOUT=16).
module tb_fifo_chunk_submit;

  localparam int DW      = 8;
  localparam int AW      = 3;
  localparam int CHUNK   = 4;
  localparam int TIMEOUT = 16;
  localparam int NSTREAM = 3 * (1 << (AW + 1));

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fifo_chunk_submit_if #(.DW(DW), .AW(AW)) bus ();

  fifo_chunk_submit #(
    .DW      (DW),
    .AW      (AW),
    .CHUNK   (CHUNK),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_en   = 1'b0;
    bus.i_data = '0;
    bus.o_rdy  = 1'b0;
`ifdef FIFO_CHUNK_SUBMIT_FLUSH_EN
    bus.i_flush = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    @(posedge clk);
    #1 rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic write_seq(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_en   = 1'b1;
      bus.i_data = base + 8'(k);
      tick();
    end
    bus.i_en = 1'b0;
  endtask

  // Expects words base..base+n-1 on consecutive cycles with o_rdy held high.
  task automatic drain_chk(input string tag, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      chk({tag, "_en"}, 32'(bus.o_en), 32'd1);
      chk({tag, "_data"}, 32'(bus.o_data), 32'(base + 8'(k)));
      tick();
    end
    chk({tag, "_en_end"}, 32'(bus.o_en), 32'd0);
    chk({tag, "_avail_end"}, 32'(bus.o_avail), 32'd0);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] e;
    int sent, got;

    idle_inputs();

    // 1: chunk fill, latency of two edges after the 4th accept
    do_reset();
    chk("rst_o_en", 32'(bus.o_en), 32'd0);
    chk("rst_i_rdy", 32'(bus.i_rdy), 32'd1);
    chk("rst_pending", 32'(bus.o_pending), 32'd0);
    chk("rst_avail", 32'(bus.o_avail), 32'd0);
    bus.o_rdy = 1'b1;
    write_seq(8'h11, 4);
    chk("t1_pending4", 32'(bus.o_pending), 32'd4);
    chk("t1_en_e0", 32'(bus.o_en), 32'd0);
    tick();
    chk("t1_en_e1", 32'(bus.o_en), 32'd0);
    chk("t1_avail", 32'(bus.o_avail), 32'd4);
    chk("t1_pending0", 32'(bus.o_pending), 32'd0);
    tick();
    drain_chk("t1", 8'h11, 4);

    // 2: idle timeout submits a short burst
    do_reset();
    bus.o_rdy = 1'b1;
    write_seq(8'h21, 3);
    chk("t2_pending3", 32'(bus.o_pending), 32'd3);
    for (int i = 1; i <= TIMEOUT; i++) begin
      tick();
      chk("t2_no_en", 32'(bus.o_en), 32'd0);
    end
    chk("t2_pending0", 32'(bus.o_pending), 32'd0);
    chk("t2_avail3", 32'(bus.o_avail), 32'd3);
    tick();
    drain_chk("t2", 8'h21, 3);
    chk("t2_pending_end", 32'(bus.o_pending), 32'd0);

    // 3: fill to full with o_rdy low; the full FIFO is released by T1
    do_reset();
    write_seq(8'h30, 4);
    tick();
    chk("t3_avail4", 32'(bus.o_avail), 32'd4);
    write_seq(8'h34, 4);
    chk("t3_full", 32'(bus.i_rdy), 32'd0);
    chk("t3_pending4", 32'(bus.o_pending), 32'd4);
    bus.i_en   = 1'b1;
    bus.i_data = 8'hEE;
    tick();
    bus.i_en = 1'b0;
    chk("t3_pending0", 32'(bus.o_pending), 32'd0);
    chk("t3_avail8", 32'(bus.o_avail), 32'd8);
    chk("t3_en", 32'(bus.o_en), 32'd1);
    chk("t3_head", 32'(bus.o_data), 32'h30);
    tick();
    chk("t3_hold", 32'(bus.o_data), 32'h30);
    bus.o_rdy = 1'b1;
    drain_chk("t3", 8'h30, 8);
    chk("t3_rdy_end", 32'(bus.i_rdy), 32'd1);

`ifdef FIFO_CHUNK_SUBMIT_FLUSH_EN
    // 4: flush on the same cycle as the 2nd write includes it
    do_reset();
    bus.o_rdy  = 1'b1;
    bus.i_en   = 1'b1;
    bus.i_data = 8'h41;
    tick();
    bus.i_data  = 8'h42;
    bus.i_flush = 1'b1;
    tick();
    bus.i_en    = 1'b0;
    bus.i_flush = 1'b0;
    chk("t4_avail2", 32'(bus.o_avail), 32'd2);
    chk("t4_pending0", 32'(bus.o_pending), 32'd0);
    tick();
    drain_chk("t4", 8'h41, 2);
`endif

    // 5: random stream across several pointer wraps against a queue model
    do_reset();
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 4000 && got < NSTREAM; cyc++) begin
      bus.i_en   = (sent < NSTREAM) && ($urandom_range(0, 3) != 0);
      bus.i_data = 8'(sent * 7 + 3);
      bus.o_rdy  = ($urandom_range(0, 2) != 0);
      chk("t5_en_no_avail", 32'(bus.o_en && (bus.o_avail == 0)), 32'd0);
      if (bus.i_en && bus.i_rdy) begin
        q.push_back(bus.i_data);
        sent++;
      end
      if (bus.o_en && bus.o_rdy) begin
        if (q.size() == 0) begin
          chk("t5_underflow", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("t5_data", 32'(bus.o_data), 32'(e));
        end
        got++;
      end
      tick();
    end
    bus.i_en = 1'b0;
    chk("t5_count", 32'(got), 32'(NSTREAM));
    chk("t5_left", 32'(q.size()), 32'd0);

    // 6: asynchronous reset mid-burst, then normal operation
    do_reset();
    write_seq(8'h50, 6);
    chk("t6_pre_en", 32'(bus.o_en), 32'd1);
    chk("t6_pre_avail", 32'(bus.o_avail), 32'd5);
    rstn = 1'b0;
    #2;
    chk("t6_rst_en", 32'(bus.o_en), 32'd0);
    chk("t6_rst_rdy", 32'(bus.i_rdy), 32'd1);
    chk("t6_rst_pending", 32'(bus.o_pending), 32'd0);
    chk("t6_rst_avail", 32'(bus.o_avail), 32'd0);
    tick();
    rstn = 1'b1;
    bus.o_rdy = 1'b1;
    write_seq(8'h61, 4);
    tick();
    tick();
    drain_chk("t6", 8'h61, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
